// File: rtl/lifo_fifo_ctrl.sv
// Sequencing controller for a 2**AW-entry, 1-bit register-file buffer.
// Generates write/read addresses and one-hot write enables in FIFO or LIFO order.
module lifo_fifo_ctrl #(
  parameter int unsigned AW = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              l_f_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              err_clr_i,
  output logic [AW-1:0]     wr_addr_o,
  output logic [2**AW-1:0]  wr_en_o,
  output logic [AW-1:0]     rd_addr_o,
  output logic [AW:0]       count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              mode_o,
  output logic              error_o,
  output logic [1:0]        err_code_o
);

  localparam int unsigned DEPTH = 2**AW;

  localparam logic [1:0] ErrOvf  = 2'b01;
  localparam logic [1:0] ErrUnf  = 2'b10;
  localparam logic [1:0] ErrMode = 2'b11;

  typedef enum logic [1:0] {
    StEmpty,
    StActive,
    StFull
  } occ_state_e;

  occ_state_e      state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            mode_q, mode_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            empty, full;
  logic            op_en;
  logic            push_ok, pop_ok;
  logic            mode_mismatch, mode_err, mode_sw;
  logic            ovf, unf;
  logic [AW:0]     count_m1;
  logic [AW-1:0]   lifo_top;

  assign empty = (state_q == StEmpty);
  assign full  = (state_q == StFull);

  // Requests are ignored while reset is held so no enable escapes during reset.
  assign op_en   = ~rst_n_i;
  assign push_ok = op_en & push_i & (~full | pop_i);
  assign pop_ok  = op_en & pop_i & ~empty;

  assign ovf = push_i & full & ~pop_i;
  assign unf = pop_i & empty;

  assign mode_mismatch = (l_f_i != mode_q);
  assign mode_err      = mode_mismatch & ((count_q != '0) | push_i);
  assign mode_sw       = mode_mismatch & empty & ~push_i;

  assign count_m1 = count_q - 1'b1;
  assign lifo_top = empty ? '0 : count_m1[AW-1:0];

  // Address generation
  always_comb begin
    wr_addr_o = wr_ptr_q;
    rd_addr_o = rd_ptr_q;
    if (mode_q) begin
      rd_addr_o = lifo_top;
      // Replace-top writes over the entry being popped, never past the end.
      wr_addr_o = (push_ok & pop_ok) ? lifo_top : count_q[AW-1:0];
    end
  end

  always_comb begin
    wr_en_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en_o[i] = push_ok & (wr_addr_o == AW'(i));
    end
  end

  // Occupancy and pointer next-state
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mode_d   = mode_q;
    state_d  = state_q;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (mode_sw) begin
      mode_d   = l_f_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (!mode_q) begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == (AW+1)'(DEPTH)) begin
      state_d = StFull;
    end else begin
      state_d = StActive;
    end
  end

  // Error next-state; a fresh error in the clear cycle takes precedence.
  always_comb begin
    error_d    = error_q;
    err_code_d = err_code_q;
    if (mode_err) begin
      error_d    = 1'b1;
      err_code_d = ErrMode;
    end else if (ovf) begin
      error_d    = 1'b1;
      err_code_d = ErrOvf;
    end else if (unf) begin
      error_d    = 1'b1;
      err_code_d = ErrUnf;
    end else if (err_clr_i) begin
      error_d    = 1'b0;
      err_code_d = 2'b00;
    end
  end

  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q    <= StEmpty;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mode_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mode_q     <= mode_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign count_o    = count_q;
  assign empty_o    = empty;
  assign full_o     = full;
  assign mode_o     = mode_q;
  assign error_o    = error_q;
  assign err_code_o = err_code_q;

endmodule

// File: doc/lifo_fifo_ctrl.md
Name: lifo_fifo_ctrl

Overview:
- Sequencing controller for the 4-entry, 1-bit register-file buffer. The buffer consists of a write demux, storage registers R0..R3 and a read mux.
- Tracks occupancy and generates the write address, one-hot register write enables and the read-mux select, in FIFO or LIFO order selected by l_f.
- Detects overflow, underflow and illegal mode switches, and reports them on a sticky error flag.
- Sits between the requesting logic (push/pop) and the storage datapath.

Parameters:
AW, 2, address width; buffer depth DEPTH = 2**AW (4 by default)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-high (1 = reset), despite the name
l_f  input  1  requested order: 1 = LIFO, 0 = FIFO
push  input  1  write request; data is presented to the datapath demux in the same cycle
pop  input  1  read request; datapath output is valid in the same cycle, consumed at the clock edge
err_clr  input  1  synchronous clear of error and err_code
wr_addr  output  AW  write demux select (combinational from state)
wr_en  output  DEPTH  one-hot register write enable, asserted only for an accepted push
rd_addr  output  AW  read mux select; always points at the entry a pop would return now
count  output  AW+1  number of stored entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
mode  output  1  active order (registered copy of l_f)
error  output  1  sticky error flag
err_code  output  2  cause of the most recent error: 01 overflow, 10 underflow, 11 mode change while non-empty

Behaviour:
- Reset (asynchronous, rst_n = 1): wr_ptr = 0, rd_ptr = 0, count = 0, mode = 0 (FIFO), error = 0, err_code = 00, occupancy FSM = EMPTY.
  - Outputs during reset: empty = 1, full = 0, wr_en = 0, wr_addr = 0, rd_addr = 0.
  - Reset in the middle of a push/pop discards that operation.
- Occupancy FSM, state registered:
  - EMPTY: count = 0.
  - ACTIVE: 0 < count < DEPTH.
  - FULL: count = DEPTH.
  - Transitions follow the count update: EMPTY->ACTIVE on an accepted push alone; ACTIVE->FULL when count reaches DEPTH; FULL->ACTIVE and ACTIVE->EMPTY on an accepted pop alone. The state must agree with count in every cycle.
- Acceptance rules, evaluated each cycle:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
  - push & full & !pop: push dropped, error set, err_code = 01.
  - pop & empty: pop dropped, error set, err_code = 10. A simultaneous push is still accepted.
- FIFO addressing (mode = 0):
  - wr_addr = wr_ptr; rd_addr = rd_ptr.
  - push_ok advances wr_ptr by 1 modulo DEPTH; pop_ok advances rd_ptr by 1 modulo DEPTH (wrap 3 -> 0).
- LIFO addressing (mode = 1):
  - wr_addr = count[AW-1:0]; rd_addr = (count - 1) mod DEPTH, and 0 when empty.
  - push_ok & pop_ok together: replace-top. wr_addr = rd_addr = count - 1; pop returns the old top combinationally and the new value is written at the edge; count is unchanged.
  - In FULL, wr_addr for push+pop is count - 1, never count (so no overflow index).
- Count update: push_ok & !pop_ok gives +1; pop_ok & !push_ok gives -1; both or neither leaves it unchanged.
- wr_en[i] = push_ok & (wr_addr == i), combinational, zero-latency. wr_en has at most one bit set.
- Mode handling:
  - l_f is sampled every cycle.
  - If l_f != mode and the buffer is empty with no push this cycle, mode <= l_f and wr_ptr = rd_ptr = 0 at the next edge.
  - If l_f != mode while count != 0 or push is asserted, mode is held, error is set, and err_code = 11. This sets error again on every cycle the mismatch persists.
- Error:
  - error is sticky and err_code holds the latest cause.
  - err_clr clears both at the next edge unless a new error occurs in that same cycle; the new error wins.
- Latency: addresses and enables are combinational from registered state (0 cycles). count, empty, full and mode update 1 cycle after the accepting edge.

Test Plan:
- Reset, FIFO fill/drain: push 4x (data 1,0,1,1) -> wr_en 0001,0010,0100,1000, full = 1, count = 4. Then pop 4x -> rd_addr 0,1,2,3, data out 1,0,1,1, empty = 1.
- FIFO wrap: push 3, pop 2, push 3 -> wr_addr sequence 0,1,2,3,0,1; count = 4, rd_addr = 2. A 5th push with no pop -> dropped, error = 1, err_code = 01, count stays 4.
- LIFO: switch l_f = 1 while empty -> mode = 1 next cycle. Push 1,0,1 -> pops return 1,0,1 with rd_addr 2,1,0. A 4th pop on empty -> error, err_code = 10.
- Simultaneous: FIFO count = 4 with push+pop -> both accepted, count = 4, wr_addr = rd_addr before the edge, no error. LIFO count = 2 with push+pop -> wr_en 0010, count = 2.
- Illegal mode change: FIFO count = 2, set l_f = 1 -> mode stays 0, error = 1, err_code = 11. After draining, mode switches; err_clr -> error = 0 next cycle.
- Async reset mid-operation: assert rst_n = 1 between edges with count = 3 in LIFO -> outputs return to reset values immediately (empty = 1, mode = 0). The next push after release writes address 0.
